// File: rtl/rtc_access_scheduler.sv
// Arbiter and sequencer for the shared RTC parallel bus: init > write > read, fixed-length grants plus guard gap.
// Optional periodic auto-read is compiled in with RTC_AUTO_READ_EN.
module rtc_access_scheduler #(
    parameter int unsigned INIT_CYCLES  = 70,
    parameter int unsigned WRITE_CYCLES = 247,
    parameter int unsigned READ_CYCLES  = 247,
    parameter int unsigned GUARD_CYCLES = 4,
    parameter int unsigned READ_PERIOD  = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       write_req,
    input  logic       read_req,
    output logic       do_it_init,
    output logic       do_it_escribir,
    output logic       do_it_leer,
    output logic [1:0] bus_sel,
    output logic       busy,
    output logic       init_done,
    output logic       write_ack,
    output logic       read_valid
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_GUARD = 3'd4;

    localparam logic [8:0] INIT_M1  = 9'(INIT_CYCLES - 1);
    localparam logic [8:0] WRITE_M1 = 9'(WRITE_CYCLES - 1);
    localparam logic [8:0] READ_M1  = 9'(READ_CYCLES - 1);
    localparam logic [8:0] GUARD_M1 = 9'(GUARD_CYCLES - 1);

    if (READ_PERIOD <= READ_CYCLES + GUARD_CYCLES) begin : g_bad_period
        $error("READ_PERIOD must exceed READ_CYCLES + GUARD_CYCLES");
    end

    logic [2:0] r_state;
    logic [8:0] r_timer;
    logic       r_init_pend;
    logic       r_write_pend;
    logic       r_read_pend;
    logic       r_do_it_init;
    logic       r_do_it_escribir;
    logic       r_do_it_leer;
    logic [1:0] r_bus_sel;
    logic       r_busy;
    logic       r_init_done;
    logic       r_write_ack;
    logic       r_read_valid;
    logic       w_tick;

`ifdef RTC_AUTO_READ_EN
    localparam logic [23:0] PERIOD_M1 = 24'(READ_PERIOD - 1);
    logic [23:0] r_period;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_period <= '0;
        end else if (r_period == PERIOD_M1) begin
            r_period <= '0;
        end else begin
            r_period <= r_period + 24'd1;
        end
    end

    assign w_tick = (r_period == PERIOD_M1);
`else
    assign w_tick = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= ST_IDLE;
            r_timer          <= '0;
            r_init_pend      <= 1'b1;
            r_write_pend     <= 1'b0;
            r_read_pend      <= 1'b0;
            r_do_it_init     <= 1'b0;
            r_do_it_escribir <= 1'b0;
            r_do_it_leer     <= 1'b0;
            r_bus_sel        <= 2'b00;
            r_busy           <= 1'b0;
            r_init_done      <= 1'b0;
            r_write_ack      <= 1'b0;
            r_read_valid     <= 1'b0;
        end else begin
            r_do_it_init     <= 1'b0;
            r_do_it_escribir <= 1'b0;
            r_do_it_leer     <= 1'b0;
            r_write_ack      <= 1'b0;
            r_read_valid     <= 1'b0;
            if (write_req)           r_write_pend <= 1'b1;
            if (read_req || w_tick)  r_read_pend  <= 1'b1;

            // Grant clears below come later in the block, so they win over a same-edge set.
            case (r_state)
                ST_IDLE: begin
                    if (r_init_pend) begin
                        r_state      <= ST_INIT;
                        r_timer      <= INIT_M1;
                        r_init_pend  <= 1'b0;
                        r_do_it_init <= 1'b1;
                        r_bus_sel    <= 2'b01;
                        r_busy       <= 1'b1;
                    end else if (r_init_done && r_write_pend) begin
                        r_state          <= ST_WRITE;
                        r_timer          <= WRITE_M1;
                        r_write_pend     <= 1'b0;
                        r_do_it_escribir <= 1'b1;
                        r_bus_sel        <= 2'b10;
                        r_busy           <= 1'b1;
                    end else if (r_init_done && r_read_pend) begin
                        r_state      <= ST_READ;
                        r_timer      <= READ_M1;
                        r_read_pend  <= 1'b0;
                        r_do_it_leer <= 1'b1;
                        r_bus_sel    <= 2'b11;
                        r_busy       <= 1'b1;
                    end
                end
                ST_INIT, ST_WRITE, ST_READ: begin
                    if (r_timer == '0) begin
                        r_state   <= ST_GUARD;
                        r_timer   <= GUARD_M1;
                        r_bus_sel <= 2'b00;
                        if (r_state == ST_INIT)  r_init_done  <= 1'b1;
                        if (r_state == ST_WRITE) r_write_ack  <= 1'b1;
                        if (r_state == ST_READ)  r_read_valid <= 1'b1;
                    end else begin
                        r_timer <= r_timer - 9'd1;
                    end
                end
                ST_GUARD: begin
                    if (r_timer == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 9'd1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_bus_sel <= 2'b00;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign do_it_init     = r_do_it_init;
    assign do_it_escribir = r_do_it_escribir;
    assign do_it_leer     = r_do_it_leer;
    assign bus_sel        = r_bus_sel;
    assign busy           = r_busy;
    assign init_done      = r_init_done;
    assign write_ack      = r_write_ack;
    assign read_valid     = r_read_valid;

endmodule

// File: tb/tb_rtc_access_scheduler.sv
// Directed bench for rtc_access_scheduler; edge numbers count rising edges after reset release.
// u_dut uses default timing, u_dut_p uses READ_PERIOD=1000 for the auto-read scenario.
module tb_rtc_access_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       write_req;
    logic       read_req;
    logic       p_read_req;

    logic       do_it_init, do_it_escribir, do_it_leer, busy, init_done, write_ack, read_valid;
    logic [1:0] bus_sel;
    logic       p_do_it_init, p_do_it_escribir, p_do_it_leer, p_busy, p_init_done, p_write_ack, p_read_valid;
    logic [1:0] p_bus_sel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rtc_access_scheduler u_dut (
        .clk            (clk),
        .reset          (reset),
        .write_req      (write_req),
        .read_req       (read_req),
        .do_it_init     (do_it_init),
        .do_it_escribir (do_it_escribir),
        .do_it_leer     (do_it_leer),
        .bus_sel        (bus_sel),
        .busy           (busy),
        .init_done      (init_done),
        .write_ack      (write_ack),
        .read_valid     (read_valid)
    );

    rtc_access_scheduler #(.READ_PERIOD(1000)) u_dut_p (
        .clk            (clk),
        .reset          (reset),
        .write_req      (1'b0),
        .read_req       (p_read_req),
        .do_it_init     (p_do_it_init),
        .do_it_escribir (p_do_it_escribir),
        .do_it_leer     (p_do_it_leer),
        .bus_sel        (p_bus_sel),
        .busy           (p_busy),
        .init_done      (p_init_done),
        .write_ack      (p_write_ack),
        .read_valid     (p_read_valid)
    );

    // {init, escribir, leer, bus_sel[1:0], busy, init_done, write_ack, read_valid}
    logic [8:0] outs, p_outs;
    assign outs   = {do_it_init, do_it_escribir, do_it_leer, bus_sel, busy, init_done, write_ack, read_valid};
    assign p_outs = {p_do_it_init, p_do_it_escribir, p_do_it_leer, p_bus_sel, p_busy, p_init_done, p_write_ack, p_read_valid};

    localparam logic [8:0] V_IDLE_DONE = 9'b000_00_0_100;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic release_reset();
        reset      = 1'b0;
        write_req  = 1'b0;
        read_req   = 1'b0;
        p_read_req = 1'b0;
        ticks(3);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        write_req  = 1'b0;
        read_req   = 1'b0;
        p_read_req = 1'b0;
        ticks(2);
        total++;
        if (outs !== 9'b0) begin
            bad++;
            $display("FAIL reset_outs got=%b exp=%b", outs, 9'b0);
        end
    endtask

    task automatic test_init();
        release_reset();
        tick();
        total++;
        if (outs !== 9'b100_01_1_000) begin bad++; $display("FAIL init_grant got=%b exp=%b", outs, 9'b100_01_1_000); end
        tick();
        total++;
        if (outs !== 9'b000_01_1_000) begin bad++; $display("FAIL init_pulse_end got=%b exp=%b", outs, 9'b000_01_1_000); end
        ticks(68);
        total++;
        if (outs !== 9'b000_01_1_000) begin bad++; $display("FAIL init_last_cycle got=%b exp=%b", outs, 9'b000_01_1_000); end
        tick();
        total++;
        if (outs !== 9'b000_00_1_100) begin bad++; $display("FAIL init_guard_entry got=%b exp=%b", outs, 9'b000_00_1_100); end
        ticks(3);
        total++;
        if (outs !== 9'b000_00_1_100) begin bad++; $display("FAIL init_guard_last got=%b exp=%b", outs, 9'b000_00_1_100); end
        tick();
        total++;
        if (outs !== V_IDLE_DONE) begin bad++; $display("FAIL init_idle got=%b exp=%b", outs, V_IDLE_DONE); end
    endtask

    task automatic test_read_during_init();
        int n11, nvalid, valid_edge;
        release_reset();
        ticks(10);
        read_req = 1'b1;
        tick();
        read_req = 1'b0;
        ticks(64);
        total++;
        if (outs !== V_IDLE_DONE) begin bad++; $display("FAIL rdi_idle_before got=%b exp=%b", outs, V_IDLE_DONE); end
        tick();
        total++;
        if (outs !== 9'b001_11_1_100) begin bad++; $display("FAIL rdi_grant got=%b exp=%b", outs, 9'b001_11_1_100); end
        n11 = 1; nvalid = 0; valid_edge = -1;
        for (int e = 77; e <= 340; e++) begin
            tick();
            if (bus_sel == 2'b11) n11++;
            if (read_valid) begin nvalid++; valid_edge = e; end
        end
        total++;
        if (n11 != 247) begin bad++; $display("FAIL rdi_len got=%0d exp=%0d", n11, 247); end
        total++;
        if (nvalid != 1 || valid_edge != 323) begin
            bad++; $display("FAIL rdi_valid got=%0d@%0d exp=1@323", nvalid, valid_edge);
        end
        total++;
        if (outs !== V_IDLE_DONE) begin bad++; $display("FAIL rdi_idle_after got=%b exp=%b", outs, V_IDLE_DONE); end
    endtask

    task automatic test_write_read_same_edge();
        int n10, nack, ack_edge, nleer;
        write_req = 1'b1;
        read_req  = 1'b1;
        tick();
        write_req = 1'b0;
        read_req  = 1'b0;
        tick();
        total++;
        if (outs !== 9'b010_10_1_100) begin bad++; $display("FAIL wr_grant got=%b exp=%b", outs, 9'b010_10_1_100); end
        n10 = 1; nack = 0; ack_edge = -1; nleer = 0;
        for (int e = 343; e <= 593; e++) begin
            tick();
            if (bus_sel == 2'b10) n10++;
            if (write_ack) begin nack++; ack_edge = e; end
            if (do_it_leer) nleer++;
        end
        total++;
        if (n10 != 247) begin bad++; $display("FAIL wr_len got=%0d exp=%0d", n10, 247); end
        total++;
        if (nack != 1 || ack_edge != 589) begin bad++; $display("FAIL wr_ack got=%0d@%0d exp=1@589", nack, ack_edge); end
        total++;
        if (nleer != 0) begin bad++; $display("FAIL wr_early_read got=%0d exp=0", nleer); end
        tick();
        total++;
        if (outs !== 9'b001_11_1_100) begin bad++; $display("FAIL wr_then_read got=%b exp=%b", outs, 9'b001_11_1_100); end
        ticks(260);
        total++;
        if (outs !== V_IDLE_DONE) begin bad++; $display("FAIL wr_idle_after got=%b exp=%b", outs, V_IDLE_DONE); end
    endtask

    task automatic test_reset_during_read();
        int ninit, nvalid, nleer;
        read_req = 1'b1;
        tick();
        read_req = 1'b0;
        tick();
        total++;
        if (outs !== 9'b001_11_1_100) begin bad++; $display("FAIL rst_rd_grant got=%b exp=%b", outs, 9'b001_11_1_100); end
        ticks(99);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (outs !== 9'b0) begin bad++; $display("FAIL rst_async got=%b exp=%b", outs, 9'b0); end
        ticks(2);
        reset = 1'b1;
        ninit = 0; nvalid = 0; nleer = 0;
        for (int e = 1; e <= 400; e++) begin
            tick();
            if (do_it_init) ninit++;
            if (read_valid) nvalid++;
            if (do_it_leer) nleer++;
            if (e == 1) begin
                total++;
                if (do_it_init !== 1'b1) begin bad++; $display("FAIL rst_reinit got=%b exp=1", do_it_init); end
            end
        end
        total++;
        if (ninit != 1 || nvalid != 0 || nleer != 0) begin
            bad++; $display("FAIL rst_after init=%0d valid=%0d leer=%0d exp=1/0/0", ninit, nvalid, nleer);
        end
        total++;
        if (outs !== V_IDLE_DONE) begin bad++; $display("FAIL rst_idle got=%b exp=%b", outs, V_IDLE_DONE); end
    endtask

    task automatic test_back_to_back();
        int first, second;
        first = -1; second = -1;
        write_req = 1'b1;
        for (int e = 401; e <= 700; e++) begin
            tick();
            if (do_it_escribir) begin
                if (first < 0) first = e;
                else if (second < 0) second = e;
            end
        end
        write_req = 1'b0;
        total++;
        if (first != 402 || second != 654) begin
            bad++; $display("FAIL b2b_starts got=%0d,%0d exp=402,654", first, second);
        end
        ticks(600);
        total++;
        if (outs !== V_IDLE_DONE) begin bad++; $display("FAIL b2b_idle got=%b exp=%b", outs, V_IDLE_DONE); end
    endtask

    task automatic test_auto_read();
        int nleer, first, main_leer, exp_n, exp_first;
`ifdef RTC_AUTO_READ_EN
        exp_n = 4; exp_first = 1001;
`else
        exp_n = 1; exp_first = 2001;
`endif
        release_reset();
        nleer = 0; first = -1; main_leer = 0;
        for (int e = 1; e <= 5000; e++) begin
            p_read_req = (e == 2000);
            tick();
            if (p_do_it_leer) begin
                nleer++;
                if (first < 0) first = e;
            end
            if (do_it_leer) main_leer++;
        end
        p_read_req = 1'b0;
        total++;
        if (nleer != exp_n || first != exp_first) begin
            bad++; $display("FAIL auto_read got=%0d@%0d exp=%0d@%0d", nleer, first, exp_n, exp_first);
        end
        total++;
        if (main_leer != 0) begin bad++; $display("FAIL auto_main_quiet got=%0d exp=0", main_leer); end
        total++;
        if (p_outs !== V_IDLE_DONE) begin bad++; $display("FAIL auto_idle got=%b exp=%b", p_outs, V_IDLE_DONE); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_read_during_init();
        test_write_read_same_edge();
        test_reset_during_read();
        test_back_to_back();
        test_auto_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
